// File: rtl/vic_pkg.sv
// Shared definitions for the nibble-wide peripheral register bus:
// register addresses, CTRL/STATUS bit positions and nibble access helpers.
package vic_pkg;

  localparam logic [4:0] ADDR_CTRL   = 5'd0;
  localparam logic [4:0] ADDR_CMP0   = 5'd1;
  localparam logic [4:0] ADDR_CMP1   = 5'd2;
  localparam logic [4:0] ADDR_CMP2   = 5'd3;
  localparam logic [4:0] ADDR_CMP3   = 5'd4;
  localparam logic [4:0] ADDR_PRESC0 = 5'd5;
  localparam logic [4:0] ADDR_PRESC1 = 5'd6;
  localparam logic [4:0] ADDR_STATUS = 5'd7;
  localparam logic [4:0] ADDR_CNT0   = 5'd8;
  localparam logic [4:0] ADDR_CNT1   = 5'd9;
  localparam logic [4:0] ADDR_CNT2   = 5'd10;
  localparam logic [4:0] ADDR_CNT3   = 5'd11;
  localparam logic [4:0] ADDR_CLR    = 5'd12;

  localparam int unsigned CTRL_EN      = 0;
  localparam int unsigned CTRL_MODE    = 1;
  localparam int unsigned CTRL_ONESHOT = 2;
  localparam int unsigned CTRL_IE      = 3;

  localparam int unsigned STATUS_PEND  = 0;

  typedef enum logic {
    MODE_LEVEL = 1'b0,
    MODE_PULSE = 1'b1
  } irq_mode_e;

  // Read nibble idx of a zero-extended 16-bit register image.
  function automatic logic [3:0] nib_rd(input logic [15:0] v, input logic [1:0] idx);
    return v[{idx, 2'b00} +: 4];
  endfunction

  // Replace nibble idx of a 16-bit register image.
  function automatic logic [15:0] nib_wr(input logic [15:0] v, input logic [1:0] idx,
                                         input logic [3:0] nib);
    logic [15:0] r;
    r = v;
    r[{idx, 2'b00} +: 4] = nib;
    return r;
  endfunction

endpackage

// File: rtl/irq_prescaler.sv
// Clock prescaler: counts 0..presc while enabled and emits tick on the
// cycle the count equals presc. A count left above a newly lowered presc
// wraps through zero before ticking again.
module irq_prescaler #(
  parameter int unsigned PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clr,
  input  logic [PRESC_W-1:0] presc,
  output logic               tick
);

  logic [PRESC_W-1:0] cnt_q, cnt_d;

  // Tick on terminal count, only while running.
  always_comb tick = en && (cnt_q == presc);

  // Advance or wrap while enabled; clear has priority.
  always_comb begin
    cnt_d = cnt_q;
    if (en) cnt_d = tick ? '0 : cnt_q + PRESC_W'(1);
    if (clr) cnt_d = '0;
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/irq_timer.sv
// Programmable interval timer with a single interrupt output (level or
// single-pulse), write-1-to-clear pending flag and nibble register bus.
module irq_timer
  import vic_pkg::*;
#(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned PRESC_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] i_regaddr,
  input  logic [3:0] i_data,
  input  logic       i_we,
  output logic [3:0] o_data,
  output logic       o_irq
);

  logic [3:0]         ctrl_q, ctrl_d;
  logic [CNT_W-1:0]   cmp_q, cmp_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               pend_q, pend_d;
  logic               pulse_q, pulse_d;
  logic               tick, match, clr_wr, w1c;
  irq_mode_e          mode;

  irq_prescaler #(.PRESC_W(PRESC_W)) u_presc (
    .clk   (clk),
    .rst   (rst),
    .en    (ctrl_q[CTRL_EN]),
    .clr   (clr_wr),
    .presc (presc_q),
    .tick  (tick)
  );

  // Bus strobes, compare result and decoded mode.
  always_comb begin
    clr_wr = i_we && (i_regaddr == ADDR_CLR);
    w1c    = i_we && (i_regaddr == ADDR_STATUS) && i_data[STATUS_PEND];
    match  = tick && (cnt_q == cmp_q);
    mode   = irq_mode_e'(ctrl_q[CTRL_MODE]);
  end

  // Register file writes; a CTRL write overrides one-shot EN clearing.
  // Nibbles beyond the register width fall off in the truncating cast.
  always_comb begin
    ctrl_d  = ctrl_q;
    cmp_d   = cmp_q;
    presc_d = presc_q;
    if (match && ctrl_q[CTRL_ONESHOT]) ctrl_d[CTRL_EN] = 1'b0;
    if (i_we) begin
      if (i_regaddr == ADDR_CTRL) begin
        ctrl_d = i_data;
      end else if (i_regaddr >= ADDR_CMP0 && i_regaddr <= ADDR_CMP3) begin
        cmp_d = CNT_W'(nib_wr(16'(cmp_q), 2'(i_regaddr - ADDR_CMP0), i_data));
      end else if (i_regaddr >= ADDR_PRESC0 && i_regaddr <= ADDR_PRESC1) begin
        presc_d = PRESC_W'(nib_wr(16'(presc_q), 2'(i_regaddr - ADDR_PRESC0), i_data));
      end
    end
  end

  // Counter/compare and interrupt state; CLR beats match, match beats W1C.
  always_comb begin
    cnt_d = cnt_q;
    if (tick) cnt_d = match ? '0 : cnt_q + CNT_W'(1);
    if (clr_wr) cnt_d = '0;
    pend_d  = match | (pend_q & ~w1c);
    pulse_d = match && (mode == MODE_PULSE);
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q  <= '0;
      cmp_q   <= '0;
      presc_q <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      cmp_q   <= cmp_d;
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      pulse_q <= pulse_d;
    end
  end

  // Combinational register read mux.
  always_comb begin
    o_data = '0;
    case (i_regaddr)
      ADDR_CTRL:                                 o_data = ctrl_q;
      ADDR_CMP0, ADDR_CMP1, ADDR_CMP2, ADDR_CMP3: o_data = nib_rd(16'(cmp_q), 2'(i_regaddr - ADDR_CMP0));
      ADDR_PRESC0, ADDR_PRESC1:                  o_data = nib_rd(16'(presc_q), 2'(i_regaddr - ADDR_PRESC0));
      ADDR_STATUS:                               o_data = {3'b000, pend_q};
      ADDR_CNT0, ADDR_CNT1, ADDR_CNT2, ADDR_CNT3: o_data = nib_rd(16'(cnt_q), i_regaddr[1:0]);
      default:                                   o_data = '0;
    endcase
  end

  // Interrupt output gated by IE, source selected by mode.
  always_comb o_irq = ctrl_q[CTRL_IE] & ((mode == MODE_PULSE) ? pulse_q : pend_q);

endmodule

// File: tb/tb_irq_timer.sv
// Self-checking bench for irq_timer: directed scenarios plus randomized
// bus traffic, every cycle compared against a behavioural register model.
module tb_irq_timer;

  localparam int unsigned CW   = 16;
  localparam int unsigned PW   = 8;
  localparam int unsigned CMAX = 1 << CW;
  localparam int unsigned PMAX = 1 << PW;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_we = 1'b0;
  logic [4:0] i_regaddr = '0;
  logic [3:0] i_data = '0;
  logic [3:0] o_data;
  logic       o_irq;

  irq_timer #(.CNT_W(CW), .PRESC_W(PW)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_regaddr (i_regaddr),
    .i_data    (i_data),
    .i_we      (i_we),
    .o_data    (o_data),
    .o_irq     (o_irq)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  bit   chk_en = 1'b0;
  logic s_irq;
  logic [3:0] s_data;

  // Reference model state.
  int unsigned m_ctrl, m_cmp, m_presc, m_cnt, m_pc;
  bit m_pend, m_pulse;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned m_read(input int unsigned a);
    if (a == 0) return m_ctrl;
    if (a >= 1 && a <= 4) return (m_cmp >> (4 * (a - 1))) & 15;
    if (a == 5 || a == 6) return (m_presc >> (4 * (a - 5))) & 15;
    if (a == 7) return m_pend ? 1 : 0;
    if (a >= 8 && a <= 11) return (m_cnt >> (4 * (a - 8))) & 15;
    return 0;
  endfunction

  function automatic int unsigned m_irq();
    if (((m_ctrl >> 3) & 1) == 0) return 0;
    if (((m_ctrl >> 1) & 1) == 1) return m_pulse ? 1 : 0;
    return m_pend ? 1 : 0;
  endfunction

  task automatic m_step(input bit r, input bit we, input int unsigned a, input int unsigned d);
    bit en, tick, match;
    int unsigned sh;
    if (r) begin
      m_ctrl = 0; m_cmp = 0; m_presc = 0; m_cnt = 0; m_pc = 0;
      m_pend = 0; m_pulse = 0;
      return;
    end
    en    = (m_ctrl & 1) == 1;
    tick  = en && (m_pc == m_presc);
    match = tick && (m_cnt == m_cmp);
    if (en) m_pc = tick ? 0 : (m_pc + 1) % PMAX;
    if (tick) m_cnt = match ? 0 : (m_cnt + 1) % CMAX;
    m_pulse = match && (((m_ctrl >> 1) & 1) == 1);
    if (we && a == 7 && (d & 1) == 1) m_pend = 0;
    if (match) m_pend = 1;
    if (match && (m_ctrl & 4) != 0) m_ctrl = m_ctrl & 14;
    if (we) begin
      if (a == 0) m_ctrl = d;
      else if (a >= 1 && a <= 4) begin
        sh = 4 * (a - 1);
        m_cmp = ((m_cmp & ~(32'd15 << sh)) | (d << sh)) % CMAX;
      end else if (a == 5 || a == 6) begin
        sh = 4 * (a - 5);
        m_presc = ((m_presc & ~(32'd15 << sh)) | (d << sh)) % PMAX;
      end else if (a == 12) begin
        m_cnt = 0;
        m_pc  = 0;
      end
    end
  endtask

  // One bus cycle: drive at negedge, sample/compare, then advance the model.
  task automatic cyc(input bit r, input bit we, input logic [4:0] a, input logic [3:0] d);
    @(negedge clk);
    rst = r; i_we = we; i_regaddr = a; i_data = d;
    #1;
    s_irq  = o_irq;
    s_data = o_data;
    if (chk_en) begin
      chk("irq", {31'd0, s_irq}, m_irq());
      chk("rd", {28'd0, s_data}, m_read(a));
    end
    @(posedge clk);
    m_step(r, we, a, d);
  endtask

  task automatic wr(input logic [4:0] a, input logic [3:0] d);
    cyc(1'b0, 1'b1, a, d);
  endtask

  task automatic rd(input logic [4:0] a);
    cyc(1'b0, 1'b0, a, 4'h0);
  endtask

  // Count idle cycles until o_irq is seen high, bounded by lim.
  task automatic wait_irq(output int n, input int lim);
    n = 0;
    do begin
      rd(5'd7);
      n++;
    end while (s_irq !== 1'b1 && n < lim);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, pulses;
    logic [3:0] beef [4];
    logic [4:0] a;
    logic [3:0] d;
    bit we, r;

    beef = '{4'hF, 4'hE, 4'hE, 4'hB};
    m_step(1'b1, 1'b0, 0, 0);
    cyc(1'b1, 1'b0, 5'd0, 4'h0);
    cyc(1'b1, 1'b0, 5'd0, 4'h0);
    chk_en = 1'b1;

    // Reset state of every mapped register.
    for (int i = 0; i <= 12; i++) begin
      rd(5'(i));
      chk("rst_rd", {28'd0, s_data}, 0);
      chk("rst_irq", {31'd0, s_irq}, 0);
    end

    // Level run: CMP=3, PRESC=0, CTRL=IE|EN.
    wr(5'd1, 4'd3); wr(5'd2, 4'd0); wr(5'd3, 4'd0); wr(5'd4, 4'd0);
    wr(5'd5, 4'd0); wr(5'd6, 4'd0); wr(5'd12, 4'd0);
    wr(5'd0, 4'b1001);
    wait_irq(n, 20);
    chk("lvl_first", n, 5);  // first enabled cycle is n=1; rise at cycle (3+1)*(0+1)
    for (int i = 0; i < 3; i++) begin
      rd(5'd7);
      chk("lvl_hold", {31'd0, s_irq}, 1);
    end
    wr(5'd7, 4'd1);
    rd(5'd7);
    chk("w1c_drop", {31'd0, s_irq}, 0);
    wait_irq(n, 20);
    chk("lvl_again", n, 3);

    // Pulse one-shot: CMP=1, PRESC=2, CTRL=1111.
    wr(5'd0, 4'd0); wr(5'd7, 4'd1);
    wr(5'd1, 4'd1); wr(5'd5, 4'd2); wr(5'd12, 4'd0);
    wr(5'd0, 4'b1111);
    wait_irq(n, 30);
    chk("pls_first", n, 7);  // rise at cycle (1+1)*(2+1) counted from n=1
    rd(5'd0);
    chk("pls_width", {31'd0, s_irq}, 0);
    chk("pls_ctrl", {28'd0, s_data}, 4'b1110);
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      rd(5'd8);
      if (s_irq === 1'b1) pulses++;
    end
    chk("pls_extra", pulses, 0);
    chk("pls_cnt", {28'd0, s_data}, 0);
    rd(5'd7);
    chk("pls_pend", {28'd0, s_data}, 1);

    // Collisions: W1C and CLR landing in a match cycle.
    wr(5'd0, 4'd0); wr(5'd7, 4'd1);
    wr(5'd1, 4'd3); wr(5'd5, 4'd0); wr(5'd12, 4'd0);
    wr(5'd0, 4'b0001);
    rd(5'd7); rd(5'd7); rd(5'd7);
    wr(5'd7, 4'd1);
    rd(5'd7);
    chk("col_w1c", {28'd0, s_data}, 1);
    wr(5'd7, 4'd1);
    rd(5'd7);
    chk("col_w1c_ok", {28'd0, s_data}, 0);
    wr(5'd12, 4'd0);
    rd(5'd8);
    chk("col_clr_cnt", {28'd0, s_data}, 0);
    rd(5'd7);
    chk("col_clr_pend", {28'd0, s_data}, 1);

    // Masking: PEND set with IE=0, then enable IE.
    chk("mask_irq", {31'd0, s_irq}, 0);
    wr(5'd0, 4'b1001);
    rd(5'd7);
    chk("unmask", {31'd0, s_irq}, 1);

    // Freeze at CNT=5 with CMP=0x20.
    wr(5'd0, 4'd0); wr(5'd1, 4'd0); wr(5'd2, 4'd2); wr(5'd12, 4'd0);
    wr(5'd0, 4'b0001);
    for (int i = 0; i < 4; i++) rd(5'd8);
    wr(5'd0, 4'd0);
    for (int i = 0; i < 20; i++) begin
      rd(5'd8);
      chk("frz_cnt", {28'd0, s_data}, 5);
    end

    // Reset mid-operation with o_irq asserted.
    wr(5'd7, 4'd1); wr(5'd1, 4'd3); wr(5'd2, 4'd0); wr(5'd12, 4'd0);
    wr(5'd0, 4'b1001);
    wait_irq(n, 20);
    chk("rmo_pre", {31'd0, s_irq}, 1);
    cyc(1'b1, 1'b0, 5'd8, 4'd0);
    rd(5'd8);
    chk("rmo_irq", {31'd0, s_irq}, 0);
    chk("rmo_cnt", {28'd0, s_data}, 0);

    // Nibble readback of CMP=0xBEEF.
    wr(5'd1, 4'hF); wr(5'd2, 4'hE); wr(5'd3, 4'hE); wr(5'd4, 4'hB);
    for (int i = 0; i < 4; i++) begin
      rd(5'(i + 1));
      chk("beef", {28'd0, s_data}, {28'd0, beef[i]});
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      r  = ($urandom % 500) == 0;
      we = ($urandom % 3) == 0;
      a  = ($urandom % 4 == 0) ? 5'($urandom % 32) : 5'($urandom % 13);
      d  = 4'($urandom % 16);
      if (we && (a == 5'd2 || a == 5'd3 || a == 5'd4 || a == 5'd6) && ($urandom % 8 != 0))
        d = 4'd0;
      cyc(r, we, a, d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
